uart_tx_frame_ctrl: RTL

- UART transmit framer; consumes par_bit from the parity calculator and drives the serial line.
- Accepts one parallel word on Data_Valid, pulses the parity-calc enable, then shifts out start, data (LSB first), optional parity and stop bits, one bit per CLK.
- CLK is the TX baud clock from the clock divider; no oversampling.
- Sits between the async FIFO/pulse-gen output and the TX pin, in the UART_CLK domain.

---
 rtl/uart_tx_frame_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit framer: start, DATA_WIDTH data bits LSB first, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to stretch STOP to two bit times.
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit on the line, parity calculator enabled
// DATA   | data bits shifting out LSB first
// PARITY | sampled par_bit on the line
// STOP   | stop bit(s) on the line
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  par_bit,
  output logic                  par_calc_en,
  output logic                  TX_OUT,
  output logic                  Busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par_en_q;
`ifdef UART_TX_TWO_STOP_EN
  logic                  stop_left;
`endif

  assign shift_nxt = shift_reg >> 1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      TX_OUT      <= 1'b1;
      Busy        <= 1'b0;
      par_calc_en <= 1'b0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      par_en_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_left   <= 1'b0;
`endif
    end else begin
      par_calc_en <= 1'b0;
      case (state)
        IDLE: begin
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
          if (Data_Valid) begin
            shift_reg   <= P_DATA;
            par_en_q    <= PAR_EN;
            TX_OUT      <= 1'b0;
            Busy        <= 1'b1;
            par_calc_en <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          TX_OUT  <= shift_reg[0];
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: begin
          shift_reg <= shift_nxt;
          bit_cnt   <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            // par_bit is looked at on this edge only; later changes cannot reach the line
            if (par_en_q) begin
              TX_OUT <= par_bit;
              state  <= PARITY;
            end else begin
              TX_OUT <= 1'b1;
              state  <= STOP;
`ifdef UART_TX_TWO_STOP_EN
              stop_left <= 1'b1;
`endif
            end
          end else begin
            TX_OUT <= shift_nxt[0];
          end
        end
        PARITY: begin
          TX_OUT <= 1'b1;
          state  <= STOP;
`ifdef UART_TX_TWO_STOP_EN
          stop_left <= 1'b1;
`endif
        end
        STOP: begin
          TX_OUT <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
          if (stop_left) begin
            stop_left <= 1'b0;
          end else begin
            Busy  <= 1'b0;
            state <= IDLE;
          end
`else
          Busy  <= 1'b0;
          state <= IDLE;
`endif
        end
        default: begin
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
